// File: rtl/ila_capture_ctrl.sv
// Capture sequencer for a dual-port trace RAM: circular pre-trigger window on port A,
// post-trigger fill, then time-ordered readout through port B.
module ila_capture_ctrl #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              trig,
    output logic [2:0]        state_o,
    output logic              done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr, start_ptr, trig_ptr;
    logic [ADDR_W-1:0] cnt, post, pretrig_q;
    logic [ADDR_W-1:0] cnt_inc, post_init;
    logic              capturing, wr, arm_ok;

    assign capturing = (state == PRE) || (state == ARMED) || (state == POST);
    // abort wins over a write presented in the same cycle
    assign wr        = smp_valid && capturing && !abort;
    assign arm_ok    = arm && !abort && ((state == IDLE) || (state == DONE));
    assign cnt_inc   = cnt + 1'b1;
    assign post_init = ADDR_W'(DEPTH - 1) - pretrig_q;

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (arm) state_n = (pretrig == '0) ? ARMED : PRE;
                PRE:        if (wr && cnt_inc == pretrig_q) state_n = ARMED;
                ARMED:      if (wr && trig) state_n = (post_init == '0) ? DONE : POST;
                POST:       if (wr && post == ADDR_W'(1)) state_n = DONE;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            start_ptr <= '0;
            trig_ptr  <= '0;
            cnt       <= '0;
            post      <= '0;
            pretrig_q <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_n;
            rd_valid <= rd_req && (state == DONE);
            if (arm_ok) begin
                wr_ptr    <= '0;
                cnt       <= '0;
                pretrig_q <= pretrig;
            end
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                case (state)
                    PRE:   cnt <= cnt_inc;
                    ARMED: if (trig) begin
                        trig_ptr <= wr_ptr;
                        post     <= post_init;
                    end
                    POST:  post <= post - 1'b1;
                    default: ;
                endcase
            end
            // trig_ptr is not yet visible when the trigger write itself completes the capture
            if (state_n == DONE && state != DONE)
                start_ptr <= ((state == ARMED) ? wr_ptr : trig_ptr) - pretrig_q;
        end
    end

    assign state_o   = state;
    assign done      = (state == DONE);
    assign ram_addra = wr_ptr;
    assign ram_dina  = smp_data;
    assign ram_wea   = wr;
    assign ram_addrb = start_ptr + rd_idx;
    assign rd_data   = ram_doutb;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Bench for ila_capture_ctrl: table-driven captures, random captures against a
// sample-stream model, and hand sequences for abort/reset/re-arm corners.
module tb_ila_capture_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clk = 0;
    logic              rst_n, arm, abort, smp_valid, trig, rd_req;
    logic [AW-1:0]     pretrig, rd_idx;
    logic [DATA_W-1:0] smp_data;
    logic [2:0]        state_o;
    logic              done, rd_valid, ram_wea;
    logic [DATA_W-1:0] rd_data, ram_dina, ram_doutb;
    logic [AW-1:0]     ram_addra, ram_addrb;
    logic [DATA_W-1:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ila_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .pretrig(pretrig),
        .smp_valid(smp_valid), .smp_data(smp_data), .trig(trig), .state_o(state_o),
        .done(done), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_data(rd_data), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    // attached dual-port RAM, 1-cycle read latency on port B
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        ram_doutb <= mem[ram_addrb];
    end

    // model: the stream of samples accepted since arm, plus their trig flags
    logic [DATA_W-1:0] q_data[$];
    bit                q_trig[$];
    int                m_pre = 0;
    bit                m_active = 0;

    function automatic int trig_pos();
        for (int i = m_pre; i < q_trig.size(); i++)
            if (q_trig[i]) return i;
        return -1;
    endfunction

    function automatic int exp_state();
        int t;
        if (!m_active) return 0;
        t = trig_pos();
        if (t < 0) return (q_data.size() < m_pre) ? 1 : 2;
        return ((q_data.size() - 1 - t) < (DEPTH - 1 - m_pre)) ? 3 : 4;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int idx);
        int t;
        t = trig_pos();
        if (t < 0) return 'x;
        return q_data[t - m_pre + idx];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_arm(input int pre);
        arm = 1; pretrig = pre[AW-1:0];
        @(posedge clk); #1;
        arm = 0;
        q_data.delete(); q_trig.delete();
        m_active = 1; m_pre = pre;
        chk("arm_state", 64'(state_o), 64'(exp_state()));
    endtask

    task automatic step_smp(input bit v, input logic [DATA_W-1:0] d, input bit t);
        int s;
        s = exp_state();
        smp_valid = v; smp_data = d; trig = t;
        @(posedge clk);
        if (v && s >= 1 && s <= 3) begin
            q_data.push_back(d);
            q_trig.push_back(t);
        end
        #1;
        chk("state", 64'(state_o), 64'(exp_state()));
    endtask

    task automatic capture(input int pre, input int ta, input int tb2, input bit tog, input bit rnd);
        int k = 0;
        int cyc = 0;
        bit v, t;
        logic [DATA_W-1:0] d;
        do_arm(pre);
        while (exp_state() != 4 && cyc < 700) begin
            v = rnd ? ($urandom_range(0, 2) != 0) : (tog ? (cyc % 2 == 1) : 1'b1);
            d = rnd ? DATA_W'($urandom) : DATA_W'(k);
            t = rnd ? ($urandom_range(0, 5) == 0) : (k == ta || k == tb2);
            step_smp(v, d, t);
            if (v) k++;
            cyc++;
        end
        smp_valid = 0; trig = 0;
        chk("done_flag", 64'(done), 64'(1));
    endtask

    task automatic read_all(input bit shuffle, output logic [DATA_W-1:0] got [DEPTH]);
        int idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx = shuffle ? int'($urandom_range(0, DEPTH - 1)) : i;
            rd_req = 1; rd_idx = idx[AW-1:0];
            @(posedge clk); #1;
            chk("rd_valid", 64'(rd_valid), 64'(1));
            chk("rd_data", 64'(rd_data), 64'(exp_data(idx)));
            got[idx] = rd_data;
        end
        rd_req = 0;
        @(posedge clk); #1;
        chk("rd_valid_idle", 64'(rd_valid), 64'(0));
    endtask

    typedef struct {
        int pre; int ta; int tb; bit tog;
        int e0; int ep; int e15;
    } vec_t;

    vec_t vecs[6];
    logic [DATA_W-1:0] got [DEPTH];

    initial begin
        vecs[0] = '{pre: 4,  ta: 10,  tb: -1, tog: 0, e0: 6,  ep: 10,  e15: 21};
        vecs[1] = '{pre: 0,  ta: 0,   tb: -1, tog: 0, e0: 0,  ep: 0,   e15: 15};
        vecs[2] = '{pre: 8,  ta: 3,   tb: 20, tog: 0, e0: 12, ep: 20,  e15: 27};
        vecs[3] = '{pre: 4,  ta: 100, tb: -1, tog: 0, e0: 96, ep: 100, e15: 111};
        vecs[4] = '{pre: 4,  ta: 100, tb: -1, tog: 1, e0: 96, ep: 100, e15: 111};
        vecs[5] = '{pre: 15, ta: 15,  tb: -1, tog: 0, e0: 0,  ep: 15,  e15: 15};

        rst_n = 0; arm = 0; abort = 0; pretrig = 0; smp_valid = 1; smp_data = 0;
        trig = 0; rd_req = 0; rd_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'(state_o), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_wea", 64'(ram_wea), 64'(0));
        rst_n = 1; smp_valid = 0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            capture(vecs[i].pre, vecs[i].ta, vecs[i].tb, vecs[i].tog, 0);
            read_all(0, got);
            chk("tbl_idx0", 64'(got[0]), 64'(vecs[i].e0));
            chk("tbl_idxpre", 64'(got[vecs[i].pre]), 64'(vecs[i].ep));
            chk("tbl_idx15", 64'(got[15]), 64'(vecs[i].e15));
        end

        // arm together with a read in DONE: read served, capture restarts
        rd_req = 1; rd_idx = 0; arm = 1; pretrig = 4;
        @(posedge clk); #1;
        chk("rearm_rd_valid", 64'(rd_valid), 64'(1));
        chk("rearm_rd_data", 64'(rd_data), 64'(exp_data(0)));
        chk("rearm_state", 64'(state_o), 64'(1));
        rd_req = 0; arm = 0;
        q_data.delete(); q_trig.delete(); m_pre = 4;

        // abort in POST
        for (int k = 0; k < 6; k++) step_smp(1, DATA_W'(k), k == 4);
        chk("post_state", 64'(state_o), 64'(3));
        abort = 1; smp_valid = 1;
        @(posedge clk); #1;
        abort = 0; smp_valid = 0; m_active = 0;
        chk("abort_state", 64'(state_o), 64'(0));
        rd_req = 1;
        @(posedge clk); #1;
        chk("abort_rd_valid", 64'(rd_valid), 64'(0));
        rd_req = 0;

        // reset while ARMED
        do_arm(3);
        for (int k = 0; k < 5; k++) step_smp(1, DATA_W'(k), 0);
        chk("armed_state", 64'(state_o), 64'(2));
        rst_n = 0; smp_valid = 1; trig = 1;
        @(posedge clk); #1;
        m_active = 0;
        chk("rst2_state", 64'(state_o), 64'(0));
        chk("rst2_done", 64'(done), 64'(0));
        chk("rst2_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst2_wea", 64'(ram_wea), 64'(0));
        rst_n = 1; smp_valid = 0; trig = 0;
        @(posedge clk); #1;

        // random captures against the stream model
        for (int r = 0; r < 10; r++) begin
            capture(int'($urandom_range(0, DEPTH - 1)), -1, -1, 0, 1);
            read_all(1, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
